vote_session_ctrl: RTL and testbench

Ballot-collection front end for the 4-input voter: runs one voting session at a time and accepts at most one vote per voter. When all four have voted or the session times out, it presents the 4-bit ballot vector to the voter over a valid/ready handshake. It then latches the voter's 3-bit verdict and reports it to the operator side. It produces the voter's I[3:0] and consumes its O[3:1].

---
 rtl/vote_pkg.sv | 31 +++
 rtl/vote_timeout_cnt.sv | 37 +++
 rtl/vote_session_ctrl.sv | 157 +++++++++++++++
 tb/tb_vote_session_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : vote_pkg                                           |
// | Description : Shared types and constants for the vote session    |
// |               controller (state encoding, sizes, helpers).       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package vote_pkg;

    localparam int N_VOTERS        = 4;
    localparam int VERDICT_W       = 3;
    localparam int TIMEOUT_CYC_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } vote_state_e;

    // Number of voters that have not voted (0..4).
    function automatic logic [2:0] count_zeros(input logic [N_VOTERS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < N_VOTERS; i++) begin
            n = n + {2'b00, ~v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vote_timeout_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : vote_timeout_cnt                                   |
// | Description : Session timer. Counts enabled cycles and flags the |
// |               last cycle of the session window.                  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module vote_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;

    // Clear wins over increment so a new session always starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_o = (count_q == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/vote_session_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : vote_session_ctrl                                  |
// | Description : Ballot-collection front end for the 4-input voter. |
// |               One vote per voter per session, close on all-voted |
// |               or timeout, ballot handed over with valid/ready,   |
// |               verdict latched and pulsed to the operator.        |
// |               Optional audit outputs under macro VOTE_AUDIT_EN.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef VOTE_AUDIT_EN
    output logic [2:0]           abstain_o,
    output logic [0:0]           timeout_o,
`endif
    input  logic                 open_i,
    input  logic [N_VOTERS-1:0]  vote_req_i,
    input  logic [N_VOTERS-1:0]  vote_val_i,
    output logic [N_VOTERS-1:0]  vote_ack_o,
    output logic [N_VOTERS-1:0]  voted_o,
    output logic                 busy_o,
    output logic [N_VOTERS-1:0]  ballot_o,
    output logic                 ballot_valid_o,
    input  logic                 ballot_ready_i,
    input  logic [VERDICT_W-1:0] verdict_i,
    output logic [VERDICT_W-1:0] result_o,
    output logic                 result_valid_o
);

    vote_state_e          state_q, state_d;
    logic [N_VOTERS-1:0]  voted_q, voted_d;
    logic [N_VOTERS-1:0]  ballot_q, ballot_d;
    logic [N_VOTERS-1:0]  ack_q, ack_d;
    logic [VERDICT_W-1:0] result_q, result_d;
    logic                 rvalid_q, rvalid_d;

    logic [N_VOTERS-1:0]  w_accept;
    logic                 w_open_acc;
    logic                 w_close;
    logic                 w_expired;

    vote_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (w_open_acc),
        .en_i      (state_q == COLLECT),
        .expired_o (w_expired)
    );

    // Next-state logic: session start, vote acceptance, close and handshake.
    always_comb begin
        state_d    = state_q;
        voted_d    = voted_q;
        ballot_d   = ballot_q;
        ack_d      = '0;
        result_d   = result_q;
        rvalid_d   = 1'b0;
        w_accept   = '0;
        w_open_acc = 1'b0;
        w_close    = 1'b0;

        case (state_q)
            IDLE: begin
                w_open_acc = open_i;
                if (w_open_acc) begin
                    state_d  = COLLECT;
                    voted_d  = '0;
                    ballot_d = '0;
                end
            end
            COLLECT: begin
                // Only first requests count; repeats from a voter are dropped.
                w_accept = vote_req_i & ~voted_q;
                voted_d  = voted_q | w_accept;
                ballot_d = (ballot_q & ~w_accept) | (vote_val_i & w_accept);
                ack_d    = w_accept;
                // Votes accepted on the closing edge are part of the ballot.
                w_close  = (&voted_d) | w_expired;
                if (w_close) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ballot_ready_i) begin
                    result_d = verdict_i;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any session in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            voted_q  <= '0;
            ballot_q <= '0;
            ack_q    <= '0;
            result_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            voted_q  <= voted_d;
            ballot_q <= ballot_d;
            ack_q    <= ack_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef VOTE_AUDIT_EN
    logic [2:0] abstain_q;
    logic       timeout_q;

    // Audit snapshot taken on the close edge; all-voted takes precedence
    // over a coincident timer expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abstain_q <= 3'd0;
            timeout_q <= 1'b0;
        end else if (w_open_acc) begin
            abstain_q <= 3'd0;
            timeout_q <= 1'b0;
        end else if (w_close) begin
            abstain_q <= count_zeros(voted_d);
            timeout_q <= ~(&voted_d);
        end
    end

    assign abstain_o = abstain_q;
    assign timeout_o = timeout_q;
`endif

    assign vote_ack_o     = ack_q;
    assign voted_o        = voted_q;
    assign ballot_o       = ballot_q;
    assign busy_o         = (state_q != IDLE);
    assign ballot_valid_o = (state_q == PRESENT);
    assign result_o       = result_q;
    assign result_valid_o = rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_vote_session_ctrl                               |
// | Description : Scoreboard bench for vote_session_ctrl with        |
// |               TIMEOUT_CYC=8. Audit checks when VOTE_AUDIT_EN.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_vote_session_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       open_i;
    logic [3:0] vote_req_i;
    logic [3:0] vote_val_i;
    logic [3:0] vote_ack_o;
    logic [3:0] voted_o;
    logic       busy_o;
    logic [3:0] ballot_o;
    logic       ballot_valid_o;
    logic       ballot_ready_i;
    logic [2:0] verdict_i;
    logic [2:0] result_o;
    logic       result_valid_o;
`ifdef VOTE_AUDIT_EN
    logic [2:0] abstain_o;
    logic [0:0] timeout_o;
`endif

    int total = 0;
    int bad   = 0;

    logic [3:0] ack_exp_q[$];
    logic [7:0] ballot_exp_q[$];
    logic [2:0] result_exp_q[$];
    logic       bv_prev = 1'b0;

    vote_session_ctrl #(
        .TIMEOUT_CYC (8),
        .CNT_W       (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef VOTE_AUDIT_EN
        .abstain_o      (abstain_o),
        .timeout_o      (timeout_o),
`endif
        .open_i         (open_i),
        .vote_req_i     (vote_req_i),
        .vote_val_i     (vote_val_i),
        .vote_ack_o     (vote_ack_o),
        .voted_o        (voted_o),
        .busy_o         (busy_o),
        .ballot_o       (ballot_o),
        .ballot_valid_o (ballot_valid_o),
        .ballot_ready_i (ballot_ready_i),
        .verdict_i      (verdict_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_session();
        open_i = 1'b1;
        tick();
        open_i = 1'b0;
    endtask

    task automatic vote(input logic [3:0] req, input logic [3:0] val, input logic [3:0] exp_ack);
        if (exp_ack != 4'b0000) ack_exp_q.push_back(exp_ack);
        vote_req_i = req;
        vote_val_i = val;
        tick();
        vote_req_i = 4'b0000;
        vote_val_i = 4'b0000;
    endtask

    task automatic handshake(input logic [2:0] verdict);
        result_exp_q.push_back(verdict);
        ballot_ready_i = 1'b1;
        verdict_i      = verdict;
        tick();
        ballot_ready_i = 1'b0;
        verdict_i      = 3'b000;
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin
        if (vote_ack_o != 4'b0000) begin
            if (ack_exp_q.size() == 0) check("unexpected_ack", {4'b0, vote_ack_o}, 8'h00);
            else check("vote_ack", {4'b0, vote_ack_o}, {4'b0, ack_exp_q.pop_front()});
        end
        if (ballot_valid_o && !bv_prev) begin
            if (ballot_exp_q.size() == 0) check("unexpected_ballot", {ballot_o, voted_o}, 8'h00);
            else check("ballot_voted", {ballot_o, voted_o}, ballot_exp_q.pop_front());
        end
        if (result_valid_o) begin
            if (result_exp_q.size() == 0) check("unexpected_result", {5'b0, result_o}, 8'h00);
            else check("result", {5'b0, result_o}, {5'b0, result_exp_q.pop_front()});
        end
        bv_prev = ballot_valid_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; open_i = 1'b0; vote_req_i = '0; vote_val_i = '0;
        ballot_ready_i = 1'b0; verdict_i = '0;
        #1;
        check("rst_outputs", {vote_ack_o, voted_o}, 8'h00);
        check("rst_ctrl", {busy_o, ballot_valid_o, result_valid_o, result_o}, 8'h00);
        check("rst_ballot", {4'b0, ballot_o}, 8'h00);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: full-vote session in separate cycles
        open_session();
        check("t1_busy", {7'b0, busy_o}, 8'h01);
        vote(4'b0001, 4'b0001, 4'b0001);
        vote(4'b0010, 4'b0000, 4'b0010);
        vote(4'b0100, 4'b0100, 4'b0100);
        check("t1_not_closed", {7'b0, ballot_valid_o}, 8'h00);
        ballot_exp_q.push_back({4'b1101, 4'b1111});
        vote(4'b1000, 4'b1000, 4'b1000);
        check("t1_bvalid_latency", {7'b0, ballot_valid_o}, 8'h01);
`ifdef VOTE_AUDIT_EN
        check("t1_abstain", {5'b0, abstain_o}, 8'h00);
        check("t1_timeout", {7'b0, timeout_o}, 8'h00);
`endif
        handshake(3'b010);
        check("t1_idle", {7'b0, busy_o}, 8'h00);
        tick();
        check("t1_result_hold", {4'b0, result_valid_o, result_o}, 8'h02);

        // 2: simultaneous votes close on the same edge
        open_session();
        check("t2_voted_clear", {voted_o, ballot_o}, 8'h00);
        ballot_exp_q.push_back({4'b0110, 4'b1111});
        vote(4'b1111, 4'b0110, 4'b1111);
        check("t2_bvalid", {7'b0, ballot_valid_o}, 8'h01);
        handshake(3'b111);

        // 3: duplicate vote ignored
        open_session();
        vote(4'b0100, 4'b0100, 4'b0100);
        vote(4'b0100, 4'b0000, 4'b0000);
        check("t3_dup_ballot", {4'b0, ballot_o}, 8'h04);
        check("t3_dup_voted", {4'b0, voted_o}, 8'h04);
        ballot_exp_q.push_back({4'b0100, 4'b1111});
        vote(4'b1011, 4'b0000, 4'b1011);
        handshake(3'b001);
        tick();

        // 4: timeout with only voter 0 voting
        open_session();
        ballot_exp_q.push_back({4'b0001, 4'b0001});
        vote(4'b0001, 4'b0001, 4'b0001);
        for (int i = 0; i < 6; i++) tick();
        check("t4_before_timeout", {7'b0, ballot_valid_o}, 8'h00);
        tick();
        check("t4_after_timeout", {7'b0, ballot_valid_o}, 8'h01);
`ifdef VOTE_AUDIT_EN
        check("t4_abstain", {5'b0, abstain_o}, 8'h03);
        check("t4_timeout", {7'b0, timeout_o}, 8'h01);
`endif

        // 5: stall in PRESENT; open and votes ignored
        for (int i = 0; i < 20; i++) begin
            open_i     = (i == 5);
            vote_req_i = (i == 10) ? 4'b0010 : 4'b0000;
            vote_val_i = (i == 10) ? 4'b0010 : 4'b0000;
            tick();
            check("t5_stall_ballot", {ballot_o, voted_o}, 8'h11);
            check("t5_stall_state", {6'b0, busy_o, ballot_valid_o}, 8'h03);
        end
        open_i = 1'b0; vote_req_i = '0; vote_val_i = '0;
        handshake(3'b101);
        check("t5_idle", {7'b0, busy_o}, 8'h00);
        tick();

        // 6: reset mid-COLLECT, then a clean session
        open_session();
        vote(4'b0001, 4'b0001, 4'b0001);
        vote(4'b0010, 4'b0010, 4'b0010);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_vec", {voted_o, ballot_o}, 8'h00);
        check("t6_rst_ctrl", {busy_o, ballot_valid_o, result_valid_o, result_o}, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        check("t6_no_rvalid", {7'b0, result_valid_o}, 8'h00);
        open_session();
        check("t6_clean", {voted_o, ballot_o}, 8'h00);
        ballot_exp_q.push_back({4'b1010, 4'b1111});
        vote(4'b1111, 4'b1010, 4'b1111);
        handshake(3'b011);
        tick(); tick();

        check("ack_q_left", 8'(ack_exp_q.size()), 8'h00);
        check("ballot_q_left", 8'(ballot_exp_q.size()), 8'h00);
        check("result_q_left", 8'(result_exp_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
